// File: rtl/thermo_rr_arbiter.sv
// rtl/thermo_rr_arbiter.sv - registered round-robin arbiter with thermometer priority mask
module thermo_rr_arbiter #(
    parameter int WIDTH = 16,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] req_i,
    output logic             grant_valid_o,
    input  logic             grant_ready_i,
    output logic [WIDTH-1:0] grant_onehot_o,
    output logic [IDXW-1:0]  grant_idx_o
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mask_q;
    logic             grant_valid_q;
    logic [WIDTH-1:0] grant_onehot_q;
    logic [IDXW-1:0]  grant_idx_q;

    logic             handshake;
    logic             any_req;
    logic [WIDTH-1:0] above_mask;
    logic [WIDTH-1:0] sel_mask;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] thermo;
    logic [WIDTH-1:0] onehot;
    logic [IDXW-1:0]  idx;

    assign handshake = grant_valid_q & grant_ready_i;
    assign any_req   = |req_i;

    // Mask that follows the current grant; applied in the handshake cycle itself
    // so back-to-back grants need no extra cycle.
    always_comb begin
        above_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            above_mask[i] = (IDXW'(i) > grant_idx_q);
        end
    end

    assign sel_mask = (state_q == GRANT) ? above_mask : mask_q;
    assign masked   = req_i & sel_mask;
    assign src      = (masked != '0) ? masked : req_i;

    always_comb begin
        logic acc;
        acc    = 1'b0;
        thermo = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc       = acc | src[i];
            thermo[i] = acc;
        end
    end

    assign onehot = thermo & ~(thermo << 1);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            mask_q         <= '1;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
            grant_idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_valid_q  <= 1'b1;
                        grant_onehot_q <= onehot;
                        grant_idx_q    <= idx;
                        state_q        <= GRANT;
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        mask_q <= above_mask;
                        if (any_req) begin
                            grant_onehot_q <= onehot;
                            grant_idx_q    <= idx;
                        end else begin
                            grant_valid_q  <= 1'b0;
                            grant_onehot_q <= '0;
                            grant_idx_q    <= '0;
                            state_q        <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign grant_valid_o  = grant_valid_q;
    assign grant_onehot_o = grant_onehot_q;
    assign grant_idx_o    = grant_idx_q;

endmodule

// File: tb/tb_thermo_rr_arbiter.sv
// tb/tb_thermo_rr_arbiter.sv - directed scoreboard bench for thermo_rr_arbiter
module tb_thermo_rr_arbiter;

    localparam int WIDTH = 4;
    localparam int IDXW  = 2;

    logic             clk = 1'b0;
    logic             rstn;
    logic [WIDTH-1:0] req;
    logic             ready;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_onehot;
    logic [IDXW-1:0]  grant_idx;

    typedef struct {
        string           tag;
        logic            valid;
        logic [IDXW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    thermo_rr_arbiter #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_i          (req),
        .grant_valid_o  (grant_valid),
        .grant_ready_i  (ready),
        .grant_onehot_o (grant_onehot),
        .grant_idx_o    (grant_idx)
    );

    task automatic step(input string tag, input logic r_n, input logic [WIDTH-1:0] r,
                        input logic rdy, input logic exp_valid, input logic [IDXW-1:0] exp_idx);
        exp_t e;
        exp_t got;
        logic [WIDTH-1:0] exp_oh;
        rstn  = r_n;
        req   = r;
        ready = rdy;
        e.tag   = tag;
        e.valid = exp_valid;
        e.idx   = exp_valid ? exp_idx : '0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got    = exp_q.pop_front();
        exp_oh = got.valid ? (WIDTH'(1) << got.idx) : '0;
        checks++;
        assert (grant_valid === got.valid) else begin
            errors++;
            $error("FAIL %s valid got=%0b exp=%0b", got.tag, grant_valid, got.valid);
        end
        checks++;
        assert (grant_idx === got.idx) else begin
            errors++;
            $error("FAIL %s idx got=%0d exp=%0d", got.tag, grant_idx, got.idx);
        end
        checks++;
        assert (grant_onehot === exp_oh) else begin
            errors++;
            $error("FAIL %s onehot got=%b exp=%b", got.tag, grant_onehot, exp_oh);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn  = 1'b0;
        req   = '0;
        ready = 1'b0;
        #1;

        // idle with no requests
        step("rst0", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step("rst1", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) step("idle", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);

        // all requesting, ready held high: 0,1,2,3,0,1 back to back
        step("rr_rst", 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
        step("rr0", 1'b1, 4'b1111, 1'b1, 1'b1, 2'd0);
        step("rr1", 1'b1, 4'b1111, 1'b1, 1'b1, 2'd1);
        step("rr2", 1'b1, 4'b1111, 1'b1, 1'b1, 2'd2);
        step("rr3", 1'b1, 4'b1111, 1'b1, 1'b1, 2'd3);
        step("rr4", 1'b1, 4'b1111, 1'b1, 1'b1, 2'd0);
        step("rr5", 1'b1, 4'b1111, 1'b1, 1'b1, 2'd1);

        // 0101 with back-pressure, then wrap
        step("bp_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step("bp0", 1'b1, 4'b0101, 1'b0, 1'b1, 2'd0);
        step("bp1", 1'b1, 4'b0101, 1'b0, 1'b1, 2'd0);
        step("bp2", 1'b1, 4'b0101, 1'b0, 1'b1, 2'd0);
        step("bp3", 1'b1, 4'b0101, 1'b0, 1'b1, 2'd0);
        step("bp_hs", 1'b1, 4'b0101, 1'b1, 1'b1, 2'd2);
        step("bp_wrap", 1'b1, 4'b0101, 1'b1, 1'b1, 2'd0);
        step("bp_idle", 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);

        // grant held while requester drops out
        step("hold_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step("hold0", 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1);
        step("hold1", 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1);
        step("hold2", 1'b1, 4'b1000, 1'b0, 1'b1, 2'd1);
        step("hold_hs", 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3);
        step("hold_idle", 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);

        // sole top requester regranted every cycle
        step("sole0", 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3);
        step("sole1", 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3);
        step("sole2", 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3);
        step("sole3", 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3);
        step("sole_idle", 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);

        // reset in the middle of a grant
        step("mr_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step("mr0", 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2);
        step("mr_drop", 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0);
        step("mr1", 1'b1, 4'b1100, 1'b0, 1'b1, 2'd2);
        step("mr_hs", 1'b1, 4'b1100, 1'b1, 1'b1, 2'd3);
        step("mr_wrap", 1'b1, 4'b1100, 1'b1, 1'b1, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
